// File: rtl/mccoy_prog_seq.sv
// mccoy_prog_seq: program sequencer for the McCoy core. Captures a short program
// over the instruction bus into a local store, then runs the core from it,
// gating its clock-enable and halting it when the PC leaves the program or the
// run-cycle budget expires.
// Optional build macro: MCCOY_SINGLE_STEP_EN (while running, each rising edge of
// step grants exactly one enabled core cycle).
// Assumes AW >= $clog2(DEPTH).
module mccoy_prog_seq #(
  parameter int unsigned   DEPTH      = 16,
  parameter int unsigned   IW         = 6,
  parameter int unsigned   AW         = 6,
  parameter logic [IW-1:0] FILL_INSTR = '0,
  parameter int unsigned   MAX_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic                   load_valid,
  input  logic [IW-1:0]          load_data,
  output logic                   load_ready,
  input  logic                   run_start,
  input  logic                   step,
  input  logic [AW-1:0]          pc_in,
  output logic [IW-1:0]          instr_out,
  output logic                   core_en,
  output logic                   core_rst,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] prog_len,
  output logic [1:0]             halt_cause
);

  localparam int unsigned AIW  = $clog2(DEPTH);
  localparam int unsigned LW   = AIW + 1;
  localparam int unsigned CW   = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam int unsigned CMPW = (AW > LW) ? AW : LW;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_PC     = 2'b01;
  localparam logic [1:0] CAUSE_BUDGET = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            en_q, en_d;
  logic            rst_q, rst_d;
  logic            ready_q, ready_d;
  logic            wr_en;
  logic            go_run;
  logic            pc_in_prog;
  logic            budget_hit;
  logic            advance;
  logic [IW-1:0]   mem [DEPTH];

  // prog_len doubles as the write pointer: words are only ever appended
  assign pc_in_prog = CMPW'(pc_in) < CMPW'(len_q);
  assign budget_hit = (MAX_CYCLES != 0) && (cnt_q == CW'(MAX_CYCLES - 1));

`ifdef MCCOY_SINGLE_STEP_EN
  logic step_q;

  // Registered edge detector: a held-high step grants only one enabled cycle
  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign advance = step & ~step_q;
`else
  logic step_unused;

  assign step_unused = step;
  assign advance     = 1'b1;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    en_d    = 1'b0;
    rst_d   = rst_q;
    wr_en   = 1'b0;
    go_run  = 1'b0;

    case (state_q)
      S_IDLE: begin
        rst_d = 1'b1;
        if (load_req) begin
          state_d = S_LOAD;
          len_d   = '0;
        end else if (run_start && (len_q != '0)) begin
          go_run = 1'b1;
        end
      end
      S_LOAD: begin
        rst_d = 1'b1;
        if (load_valid && ready_q) begin
          wr_en = 1'b1;
          len_d = len_q + LW'(1);
        end
        if (run_start) begin
          if (len_d != '0) go_run  = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rst_d = 1'b0;
        if (en_q) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
          if (!pc_in_prog) begin
            state_d = S_HALT;
            cause_d = CAUSE_PC;
          end else if (budget_hit) begin
            state_d = S_HALT;
            cause_d = CAUSE_BUDGET;
          end
        end
        if (state_d == S_RUN) en_d = advance;
      end
      S_HALT: begin
        rst_d = 1'b0;
        if (load_req) begin
          state_d = S_LOAD;
          len_d   = '0;
          rst_d   = 1'b1;
        end else if (run_start) begin
          go_run = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // RUN entry: one-cycle core reset, fresh budget, cleared cause
    if (go_run) begin
      state_d = S_RUN;
      cnt_d   = '0;
      cause_d = CAUSE_NONE;
      rst_d   = 1'b1;
      en_d    = 1'b0;
    end

    ready_d = (state_d == S_LOAD) && (len_d < LW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      en_q    <= 1'b0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Program store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[len_q[AIW-1:0]] <= load_data;
  end

  assign instr_out  = pc_in_prog ? mem[pc_in[AIW-1:0]] : FILL_INSTR;
  assign load_ready = ready_q;
  assign core_en    = en_q;
  assign core_rst   = rst_q;
  assign state      = state_q;
  assign prog_len   = len_q;
  assign halt_cause = cause_q;

endmodule
